im_loader: RTL and testbench

Boot-time writer for instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and drives a synchronous write port into a writable IMEM, word-indexed the same way IMEM is read (IMEM[IMA]). It holds the pipeline in stall while loading and reports success or checksum/length error. It sits between the host/UART byte source and the IMEM write side; the CPU fetch path is untouched.

---
 rtl/im_loader_pkg.sv | 20 ++
 rtl/im_loader_if.sv | 22 ++
 rtl/im_loader_byte_packer.sv | 32 +++
 rtl/im_loader.sv | 136 +++++++++++++
 tb/tb_im_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/im_loader_pkg.sv
// im_loader shared definitions.
// State encoding, field widths and defaults.
package im_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;
    localparam int CSUM_W    = 8;
    localparam int DEPTH_DEF = 32;
    localparam int CW_DEF    = 8;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream valid/ready link.
// master = byte source, slave = loader.
interface im_loader_if;
    import im_loader_pkg::*;

    logic              BVALID;
    logic [BYTE_W-1:0] BDATA;
    logic              BREADY;

    modport master (
        output BVALID,
        output BDATA,
        input  BREADY
    );

    modport slave (
        input  BVALID,
        input  BDATA,
        output BREADY
    );

endinterface

// File: rtl/im_loader_byte_packer.sv
// 8->32 big-endian word assembler.
// word/word_valid are valid in the cycle of the 4th byte.
module byte_packer
    import im_loader_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clr,
    input  logic              load,
    input  logic [BYTE_W-1:0] din,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [1:0]               cnt;
    logic [WORD_W-BYTE_W-1:0] sr;

    // shift in accepted bytes, MSB first, and count position in the word
    always_ff @(posedge CLK) begin
        if (!RST_N || clr) begin
            cnt <= '0;
            sr  <= '0;
        end else if (load) begin
            cnt <= cnt + 2'd1;
            sr  <= {sr[WORD_W-2*BYTE_W-1:0], din};
        end
    end

    assign word       = {sr, din};
    assign word_valid = load && (cnt == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Boot-time IMEM loader: byte frame -> IMEM writes.
// Holds the CPU while loading; reports done or error.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    im_loader_if.slave        bs,
    output logic              IMWE,
    output logic [WORD_W-1:0] IMWA,
    output logic [WORD_W-1:0] IMWD,
    output logic              CPU_HOLD,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR
);

    state_t              state;
    state_t              state_nx;
    logic [CW-1:0]       n_words;
    logic [CW-1:0]       wcnt;
    logic [CSUM_W-1:0]   csum;
    logic [CW-1:0]       hdr_n;
    logic                acc;
    logic                start_acc;
    logic                data_acc;
    logic                last_word;
    logic [WORD_W-1:0]   word;
    logic                word_valid;

    assign acc       = bs.BVALID && bs.BREADY;
    assign start_acc = (state == S_IDLE) && START;
    assign data_acc  = acc && (state == S_DATA);
    assign hdr_n     = CW'(bs.BDATA);
    assign last_word = (wcnt == n_words - 1'b1);

    byte_packer u_pack (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clr        (start_acc),
        .load       (data_acc),
        .din        (bs.BDATA),
        .word       (word),
        .word_valid (word_valid)
    );

    // state register
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (START) state_nx = S_HDR;
            S_HDR: begin
                if (acc) begin
                    if (hdr_n > CW'(DEPTH)) state_nx = S_ERR;
                    else if (hdr_n == '0)   state_nx = S_CSUM;
                    else                    state_nx = S_DATA;
                end
            end
            S_DATA: if (word_valid && last_word) state_nx = S_CSUM;
            S_CSUM: begin
                if (acc) begin
                    if (bs.BDATA == csum) state_nx = S_DONE;
                    else                  state_nx = S_ERR;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        bs.BREADY = 1'b0;
        CPU_HOLD  = 1'b1;
        LOAD_DONE = 1'b0;
        unique case (state)
            S_IDLE: CPU_HOLD  = 1'b0;
            S_HDR:  bs.BREADY = 1'b1;
            S_DATA: bs.BREADY = 1'b1;
            S_CSUM: bs.BREADY = 1'b1;
            S_DONE: LOAD_DONE = 1'b1;
            S_ERR:  LOAD_DONE = 1'b0;
            default: CPU_HOLD = 1'b1;
        endcase
    end

    // frame bookkeeping: header count, word index, running XOR
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            n_words <= '0;
            wcnt    <= '0;
            csum    <= '0;
        end else begin
            if (start_acc) begin
                wcnt <= '0;
                csum <= '0;
            end
            if (acc && state == S_HDR) n_words <= hdr_n;
            if (data_acc)              csum    <= csum ^ bs.BDATA;
            if (word_valid)            wcnt    <= wcnt + 1'b1;
        end
    end

    // registered IMEM write port; address/data hold between writes
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            IMWE <= 1'b0;
            IMWA <= '0;
            IMWD <= '0;
        end else begin
            IMWE <= word_valid;
            if (word_valid) begin
                IMWA <= WORD_W'(wcnt);
                IMWD <= word;
            end
        end
    end

    // sticky error flag, cleared when a new load is armed
    always_ff @(posedge CLK) begin
        if (!RST_N)           LOAD_ERR <= 1'b0;
        else if (start_acc)   LOAD_ERR <= 1'b0;
        else if (state == S_ERR) LOAD_ERR <= 1'b1;
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader.
// Random frames vs. a frame-level reference model.
module tb_im_loader;
    import im_loader_pkg::*;

    localparam int DEPTH = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        IMWE;
    logic [31:0] IMWA;
    logic [31:0] IMWD;
    logic        CPU_HOLD;
    logic        LOAD_DONE;
    logic        LOAD_ERR;

    im_loader_if bif ();

    im_loader #(.DEPTH(DEPTH), .CW(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .bs        (bif),
        .IMWE      (IMWE),
        .IMWA      (IMWA),
        .IMWD      (IMWD),
        .CPU_HOLD  (CPU_HOLD),
        .LOAD_DONE (LOAD_DONE),
        .LOAD_ERR  (LOAD_ERR)
    );

    always #5 CLK = ~CLK;

    wr_t         exp_q[$];
    logic [31:0] words[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_d = '0;
    wr_t         e_m;

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // monitor: pops expected writes whenever the DUT writes
    always @(negedge CLK) begin
        if (!RST_N) begin
            last_a = '0;
            last_d = '0;
        end else begin
            if (LOAD_DONE) done_cnt++;
            if (IMWE) begin
                check("hold_in_write", 32'(CPU_HOLD), 32'd1);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: IMWA=%0d IMWD=%h, no write required",
                             IMWA, IMWD);
                end else begin
                    e_m = exp_q.pop_front();
                    check("write_addr", IMWA, e_m.a);
                    check("write_data", IMWD, e_m.d);
                end
                last_a = IMWA;
                last_d = IMWD;
            end else begin
                check("imwa_hold", IMWA, last_a);
                check("imwd_hold", IMWD, last_d);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bif.BVALID = 1'b0;
                tick();
            end
        end
        bif.BVALID = 1'b1;
        bif.BDATA  = b;
        t = 0;
        while (!bif.BREADY && t < 100) begin
            tick();
            t++;
        end
        if (!bif.BREADY) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_timeout: BREADY=0, byte %h never accepted", b);
        end
        tick();
    endtask

    task automatic arm();
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_hold", 32'(CPU_HOLD), 32'd1);
        check("start_bready", 32'(bif.BREADY), 32'd1);
        check("start_err_clr", 32'(LOAD_ERR), 32'd0);
    endtask

    task automatic run_frame(input int n, input bit bad, input bit gaps);
        logic [7:0]  x;
        logic [31:0] wv;
        int          d0;
        wr_t         w;
        d0 = done_cnt;
        arm();
        send_byte(8'(n), gaps);
        if (n > DEPTH) begin
            bif.BVALID = 1'b0;
            tick();
            check("ovf_err", 32'(LOAD_ERR), 32'd1);
            check("ovf_bready", 32'(bif.BREADY), 32'd0);
            check("ovf_hold", 32'(CPU_HOLD), 32'd0);
            repeat (3) tick();
            check("ovf_done_cnt", 32'(done_cnt - d0), 32'd0);
            return;
        end
        x = '0;
        for (int i = 0; i < n; i++) begin
            wv  = words[i];
            w.a = 32'(i);
            w.d = wv;
            exp_q.push_back(w);
            for (int b = 0; b < 4; b++) begin
                x ^= wv[31-8*b -: 8];
                send_byte(wv[31-8*b -: 8], gaps);
            end
        end
        if (bad) x ^= 8'($urandom_range(1, 255));
        send_byte(x, gaps);
        bif.BVALID = 1'b0;
        check("end_done", 32'(LOAD_DONE), 32'(!bad));
        check("end_hold", 32'(CPU_HOLD), 32'd1);
        tick();
        check("post_hold", 32'(CPU_HOLD), 32'd0);
        check("post_done", 32'(LOAD_DONE), 32'd0);
        check("post_err", 32'(LOAD_ERR), 32'(bad));
        tick();
        check("done_cnt", 32'(done_cnt - d0), 32'(!bad));
        check("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outs();
        check("rst_bready", 32'(bif.BREADY), 32'd0);
        check("rst_imwe", 32'(IMWE), 32'd0);
        check("rst_imwa", IMWA, 32'd0);
        check("rst_imwd", IMWD, 32'd0);
        check("rst_hold", 32'(CPU_HOLD), 32'd0);
        check("rst_done", 32'(LOAD_DONE), 32'd0);
        check("rst_err", 32'(LOAD_ERR), 32'd0);
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wr_t w;
        logic [31:0] wv;
        bif.BVALID = 1'b0;
        bif.BDATA  = '0;
        RST_N      = 1'b0;
        repeat (3) tick();
        check_reset_outs();
        RST_N = 1'b1;
        tick();

        words.delete();
        words.push_back(32'h2010_0000);
        words.push_back(32'h2011_0005);
        run_frame(2, 1'b0, 1'b0);
        run_frame(2, 1'b1, 1'b0);
        run_frame(33, 1'b0, 1'b0);
        words.delete();
        run_frame(0, 1'b0, 1'b0);

        rand_words(32);
        run_frame(32, 1'b0, 1'b1);

        rand_words(3);
        arm();
        send_byte(8'd3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            w.a = 32'(i);
            w.d = words[i];
            exp_q.push_back(w);
        end
        for (int k = 0; k < 10; k++) begin
            wv = words[k/4];
            send_byte(wv[31-8*(k%4) -: 8], 1'b0);
        end
        bif.BVALID = 1'b0;
        RST_N = 1'b0;
        tick();
        check_reset_outs();
        repeat (3) tick();
        RST_N = 1'b1;
        tick();
        check("rst_writes_left", 32'(exp_q.size()), 32'd0);
        rand_words(3);
        run_frame(3, 1'b0, 1'b0);

        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(1, 8);
            rand_words(n);
            run_frame(n, 1'($urandom_range(0, 1)), 1'b1);
        end
        rand_words(32);
        run_frame(32, 1'b1, 1'b1);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
